// File: rtl/riscv_32_pkg.sv
// Shared constants for the RV32 pipeline: canonical NOP, reset PC and the
// default instruction-memory word-address width.
package riscv_32_pkg;

  // ADDI x0, x0, 0
  localparam logic [31:0] RV32_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;
  localparam int          IMEM_AW_DEF   = 12;

  // Instruction fetches are word aligned; drop the byte offset.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/riscv_32_pc_reg.sv
// Fetch program counter (pc_F). Reset loads RESET_PC, a redirect loads the
// already-aligned target (and beats stall), stall holds, otherwise +4 with
// natural 32-bit wrap.
import riscv_32_pkg::*;

module riscv_32_pc_reg #(
  parameter logic [31:0] RESET_PC = RV32_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_tgt,
  output logic [31:0] pc_F
);

  // Next-fetch PC with reset > redirect > stall > increment priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_F <= RESET_PC;
    end else if (redirect_valid) begin
      pc_F <= redirect_tgt;
    end else if (!stall) begin
      pc_F <= pc_F + 32'd4;
    end
  end

endmodule

// File: rtl/riscv_32_fetch_stage.sv
// Instruction-fetch stage of the 3-stage RV32 core. Drives the synchronous
// instruction memory, tracks the PC of the word on imem_rdata, and inserts a
// single NOP bubble after each redirect.
// Optional build macro: FETCH_MISALIGN_TRAP_EN -- when defined, a redirect
// whose target has non-zero low bits sets the sticky misalign_err flag;
// otherwise misalign_err is constant 0. The redirect is aligned either way.
import riscv_32_pkg::*;

module riscv_32_fetch_stage #(
  parameter logic [31:0] RESET_PC = RV32_RESET_PC,
  parameter int          IMEM_AW  = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr_D,
  output logic [31:0]        pc_D,
  output logic [31:0]        pc_plus4_D,
  output logic               valid_D,
  output logic               misalign_err
);

  logic [31:0] pc_F;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = align_word(redirect_pc);

  riscv_32_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_tgt   (redirect_tgt),
    .pc_F           (pc_F)
  );

  // While stalled the memory re-reads pc_D so imem_rdata stays put.
  assign imem_addr = stall ? pc_D[IMEM_AW+1:2] : pc_F[IMEM_AW+1:2];

  // Decode-side PC and bubble flag; pc_D is simply held across a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_D    <= 32'h0000_0000;
      valid_D <= 1'b0;
    end else if (redirect_valid) begin
      valid_D <= 1'b0;
    end else if (!stall) begin
      pc_D    <= pc_F;
      valid_D <= 1'b1;
    end
  end

  // Bubble mux and link value are combinational off the decode registers.
  assign instr_D    = valid_D ? imem_rdata : RV32_NOP;
  assign pc_plus4_D = pc_D + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky flag: any misaligned redirect target sets it until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_32_fetch_stage.sv
// Scoreboard bench for riscv_32_fetch_stage: the driver pushes the expected
// decode-side view for each issued cycle, the monitor pops and compares it
// one clock later.
module tb_riscv_32_fetch_stage;

  localparam int          AW   = 12;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr_D;
  logic [31:0]   pc_D;
  logic [31:0]   pc_plus4_D;
  logic          valid_D;
  logic          misalign_err;

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  riscv_32_fetch_stage #(
    .RESET_PC (RPC),
    .IMEM_AW  (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_D        (instr_D),
    .pc_D           (pc_D),
    .pc_plus4_D     (pc_plus4_D),
    .valid_D        (valid_D),
    .misalign_err   (misalign_err)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] next_fetch;
  int          vectors = 0;
  int          miscompares = 0;

  // Memory is 4096 words; higher address bits alias.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[int'((a >> 2) & 32'h0000_0FFF)];
  endfunction

  // Reference model: what the decoder sees next cycle, from the fetch rules.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    if (r) begin
      cur.v = 1'b0; cur.pc = 32'h0; cur.instr = NOP; cur.err = 1'b0;
      next_fetch = RPC;
    end else if (rv) begin
      cur.v = 1'b0; cur.instr = NOP;
      next_fetch = {rp[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rp[1:0] != 2'b00) cur.err = 1'b1;
`endif
    end else if (!s) begin
      cur.v = 1'b1; cur.pc = next_fetch; cur.instr = word_at(next_fetch);
      next_fetch = next_fetch + 32'd4;
    end
    q.push_back(cur);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: the DUT presents one decode-side view per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_D",      {31'b0, valid_D},      {31'b0, e.v});
        chk("instr_D",      instr_D,               e.instr);
        chk("pc_D",         pc_D,                  e.pc);
        chk("pc_plus4_D",   pc_plus4_D,            e.pc + 32'd4);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0]    = 32'h0010_0093;
    mem[1]    = 32'h0020_0113;
    mem[16]   = 32'h0050_0193;
    cur = '{v: 1'b0, pc: 32'h0, instr: NOP, err: 1'b0};
    next_fetch = RPC;

    // Reset, sequential fetch, redirect to 0x40 from PC 0x8.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40); step(0, 0, 0, 0); step(0, 0, 0, 0);

    // Three-cycle stall while pc_D = 4.
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);

    // Redirect with stall, then stall held on the bubble.
    step(0, 1, 1, 32'h100); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h200); step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);

    // Misaligned redirect, sticky flag, reset clears it.
    step(0, 0, 1, 32'h42); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h80); step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0);

    // Reset landing on a redirect-in-flight.
    step(0, 0, 1, 32'h300); step(1, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, rv;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 20);
      rv = ($urandom_range(0, 99) < 10);
      step(r, s, rv, $urandom);
    end
    step(0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_32_fetch_stage.md
# riscv_32_fetch_stage

Instruction-fetch stage of the 3-stage RV32 CPU. It owns the program counter, addresses the synchronous-read instruction memory, and presents the fetched instruction word plus its PC to the instruction decoder. It accepts PC redirects from the execute stage (taken branches and jumps whose targets come from the decoder's B/J/I immediates) and a stall from the hazard logic. It inserts a NOP bubble on every redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `IMEM_AW`, default 12: instruction memory word-address width (4096 words).
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: hold the fetch and decode-side registers.
- `redirect_valid` input 1: execute stage requests a PC change this cycle.
- `redirect_pc` input 32: target PC for the redirect.
- `imem_addr` output IMEM_AW: word address to the instruction memory.
- `imem_rdata` input 32: instruction memory data, valid 1 cycle after its address.
- `instr_D` output 32: instruction to the decoder; equals NOP when `valid_D`=0.
- `pc_D` output 32: PC of `instr_D`.
- `pc_plus4_D` output 32: `pc_D`+4, used for the JAL/JALR link value.
- `valid_D` output 1: `instr_D` is a real instruction, not a bubble.
- `misalign_err` output 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- Registers:
  - `pc_F`: next PC to fetch.
  - `pc_D`: PC whose data is on `imem_rdata`.
  - `valid_D`: bubble/valid flag for `instr_D`.
  - `misalign_err`: sticky error flag.
- Address mux: `imem_addr` = `stall` ? `pc_D[IMEM_AW+1:2]` : `pc_F[IMEM_AW+1:2]`.
  - During a stall the memory re-reads `pc_D`, so `imem_rdata` stays constant.
- `instr_D` = `valid_D` ? `imem_rdata` : NOP (32'h0000_0013). This path is combinational.
- Per-cycle priority, highest first:
  1. `rst`: `pc_F`←RESET_PC, `pc_D`←0, `valid_D`←0, `misalign_err`←0.
  2. `redirect_valid`: `pc_F`←redirect target, `valid_D`←0. `pc_D` is don't-care and is held. Redirect overrides `stall`.
  3. `stall`: all registers hold.
  4. Normal: `pc_D`←`pc_F`, `pc_F`←`pc_F`+4, `valid_D`←1.
- Arithmetic:
  - PC adds are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
  - Address bits above IMEM_AW+1 are ignored, so addresses alias.
- No FSM beyond the valid/bubble flag. Every redirect yields exactly one bubble before the target instruction.

## Timing
- Fetch latency: the instruction at `pc_F` appears on `instr_D` one cycle after `pc_F` is presented (registered address into the synchronous memory).
- After `rst` deasserts:
  - Cycle 0: `valid_D`=0, `instr_D`=NOP.
  - Cycle 1: `instr_D`=mem[RESET_PC], `pc_D`=RESET_PC.
- Redirect asserted in cycle n:
  - Cycle n+1: bubble.
  - Cycle n+2: `instr_D`=mem[target], `pc_D`=target.
- Stall for k cycles: `instr_D`, `pc_D` and `valid_D` are frozen for k cycles. The sequence resumes with no loss or duplication.
- Redirect and stall in the same cycle: the redirect wins and the bubble follows. A stall on the bubble cycle holds the bubble.
- Reset asserted mid-stream or mid-redirect: the next cycle matches the post-reset cycle 0.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `misalign_err` (sticky until `rst`).
  - The redirect is still taken, with the low bits cleared.
- Not defined: low bits are silently cleared and `misalign_err` is tied to 0.

## Structure
- Shared package `riscv_32_pkg` holds:
  - `RV32_NOP` (32'h0000_0013).
  - `RV32_RESET_PC`.
  - `IMEM_AW_DEF`.
- One natural sub-module: `riscv_32_pc_reg`, the `pc_F` register with its reset/redirect/stall/increment mux. The address mux, decode-side registers and bubble mux stay in the top module.

## Test plan
- Reset, RESET_PC=0, memory holds 0x00100093 at word 0 and 0x00200113 at word 1, no stall → `valid_D` 0,1,1; `instr_D` NOP, 0x00100093, 0x00200113; `pc_D` –, 0, 4.
- Redirect to 0x40 at PC 0x8, mem[0x40]=0x00500193 → one NOP bubble, then `pc_D`=0x40, `instr_D`=0x00500193, `pc_plus4_D`=0x44.
- Stall for 3 cycles while `pc_D`=0x4 → `instr_D`/`pc_D` frozen 3 cycles, then `pc_D`=0x8 with no skipped or repeated word.
- Redirect and stall in the same cycle, target 0x100 → redirect taken; bubble; `pc_D`=0x100 two cycles later.
- `pc_F`=0xFFFF_FFFC → next `pc_F`=0; `pc_plus4_D`=0 when `pc_D`=0xFFFF_FFFC.
- Redirect to 0x42 → fetch from 0x40. `misalign_err`=1 and sticky with `FETCH_MISALIGN_TRAP_EN`, 0 without it; `rst` clears it.
